accel_seq_ctrl: RTL and testbench

ACCEL_SEQ_CTRL -- requirements
Module: accel_seq_ctrl

---
 rtl/accel_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_accel_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_seq_ctrl.sv
// Accelerator job sequencer: copies a source block into accelerator
// memory, starts the accelerator, then copies its result out.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cfg_start         single-cycle job request, sampled in IDLE only
//   cfg_in_words      input block length in words
//   cfg_src_base      source byte base address
//   cfg_dst_base      destination byte base address
//   busy              high while a job is in progress
//   done_irq          one-cycle completion pulse
//   status            0 = OK, 1 = TIMEOUT, 2 = LEN_ERR
//   src_en            source read strobe
//   src_addr          source byte address
//   src_rdata         source read data, one cycle after src_en
//   acc_start         accelerator start pulse
//   acc_done          accelerator completion
//   acc_out_len       accelerator output length in bytes
//   acc_mem_en        accelerator memory enable
//   acc_mem_we        accelerator memory write enable
//   acc_mem_addr      accelerator memory word index
//   acc_mem_be        accelerator memory byte enables
//   acc_mem_wdata     accelerator memory write data
//   acc_mem_rdata     accelerator memory read data, one cycle after read
//   dst_we            destination write strobe
//   dst_addr          destination byte address
//   dst_wdata         destination write data
module accel_seq_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_IN_WORDS   = 43,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_start,
   input  logic [5:0]              cfg_in_words,
   input  logic [ADDR_WIDTH-1:0]   cfg_src_base,
   input  logic [ADDR_WIDTH-1:0]   cfg_dst_base,
   output logic                    busy,
   output logic                    done_irq,
   output logic [1:0]              status,
   output logic                    src_en,
   output logic [ADDR_WIDTH-1:0]   src_addr,
   input  logic [DATA_WIDTH-1:0]   src_rdata,
   output logic                    acc_start,
   input  logic                    acc_done,
   input  logic [5:0]              acc_out_len,
   output logic                    acc_mem_en,
   output logic                    acc_mem_we,
   output logic [ADDR_WIDTH-1:0]   acc_mem_addr,
   output logic [DATA_WIDTH/8-1:0] acc_mem_be,
   output logic [DATA_WIDTH-1:0]   acc_mem_wdata,
   input  logic [DATA_WIDTH-1:0]   acc_mem_rdata,
   output logic                    dst_we,
   output logic [ADDR_WIDTH-1:0]   dst_addr,
   output logic [DATA_WIDTH-1:0]   dst_wdata
);

   localparam int CW = (TIMEOUT_CYCLES > 63) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 7;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_TIMEOUT = 2'd1;
   localparam logic [1:0] ST_LEN_ERR = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_UNLOAD,
      S_DONE
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_m1;
   logic [5:0]            n_words;
   logic [4:0]            m_words;
   logic [4:0]            m_next;
   logic [ADDR_WIDTH-1:0] src_base;
   logic [ADDR_WIDTH-1:0] dst_base;

   assign cnt_m1 = cnt - CW'(1);
   assign m_next = 5'((7'(acc_out_len) + 7'd3) >> 2);

   // Strobes are registered, so read data returns while the matching
   // write strobe is up; write data is forwarded straight from it.
   assign acc_mem_wdata = acc_mem_we ? src_rdata : '0;
   assign dst_wdata     = dst_we ? acc_mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         n_words      <= '0;
         m_words      <= '0;
         src_base     <= '0;
         dst_base     <= '0;
         busy         <= 1'b0;
         done_irq     <= 1'b0;
         status       <= ST_OK;
         src_en       <= 1'b0;
         src_addr     <= '0;
         acc_start    <= 1'b0;
         acc_mem_en   <= 1'b0;
         acc_mem_we   <= 1'b0;
         acc_mem_addr <= '0;
         acc_mem_be   <= '0;
         dst_we       <= 1'b0;
         dst_addr     <= '0;
      end else begin
         done_irq   <= 1'b0;
         acc_start  <= 1'b0;
         src_en     <= 1'b0;
         acc_mem_en <= 1'b0;
         acc_mem_we <= 1'b0;
         acc_mem_be <= '0;
         dst_we     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               cnt <= '0;
               if (cfg_start) begin
                  src_base <= cfg_src_base;
                  dst_base <= cfg_dst_base;
                  n_words  <= cfg_in_words;
                  busy     <= 1'b1;
                  if (cfg_in_words != 6'd0 &&
                      int'(cfg_in_words) <= MAX_IN_WORDS) begin
                     status <= ST_OK;
                     state  <= S_LOAD;
                  end else begin
                     status <= ST_LEN_ERR;
                     state  <= S_DONE;
                  end
               end
            end
            // cnt = k issues read k and writes word k-1.
            S_LOAD: begin
               if (cnt < CW'(n_words)) begin
                  src_en   <= 1'b1;
                  src_addr <= src_base + (ADDR_WIDTH'(cnt) << 2);
               end
               if (cnt != '0) begin
                  acc_mem_en   <= 1'b1;
                  acc_mem_we   <= 1'b1;
                  acc_mem_be   <= '1;
                  acc_mem_addr <= ADDR_WIDTH'(cnt_m1);
               end
               if (cnt == CW'(n_words)) begin
                  cnt   <= '0;
                  state <= S_START;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_START: begin
               acc_start <= 1'b1;
               cnt       <= '0;
               state     <= S_WAIT;
            end
            // acc_done wins over a timeout in the same cycle.
            S_WAIT: begin
               if (acc_done) begin
                  m_words <= m_next;
                  cnt     <= '0;
                  if (m_next == 5'd0) begin
                     status <= ST_OK;
                     state  <= S_DONE;
                  end else begin
                     state <= S_UNLOAD;
                  end
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  status <= ST_TIMEOUT;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_UNLOAD: begin
               if (cnt < CW'(m_words)) begin
                  acc_mem_en   <= 1'b1;
                  acc_mem_addr <= ADDR_WIDTH'(cnt);
               end
               if (cnt != '0) begin
                  dst_we   <= 1'b1;
                  dst_addr <= dst_base + (ADDR_WIDTH'(cnt_m1) << 2);
               end
               if (cnt == CW'(m_words)) begin
                  cnt    <= '0;
                  status <= ST_OK;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               done_irq <= 1'b1;
               busy     <= 1'b0;
               cnt      <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Scoreboard bench for accel_seq_ctrl with source, accelerator
// and memory models; directed jobs, decoupled output monitor.
module tb_accel_seq_ctrl;

   localparam int T = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start = 1'b0;
   logic [5:0]  cfg_in_words = '0;
   logic [31:0] cfg_src_base = '0;
   logic [31:0] cfg_dst_base = '0;
   logic        busy;
   logic        done_irq;
   logic [1:0]  status;
   logic        src_en;
   logic [31:0] src_addr;
   logic [31:0] src_rdata = '0;
   logic        acc_start;
   logic        acc_done = 1'b0;
   logic [5:0]  acc_out_len = '0;
   logic        acc_mem_en;
   logic        acc_mem_we;
   logic [31:0] acc_mem_addr;
   logic [3:0]  acc_mem_be;
   logic [31:0] acc_mem_wdata;
   logic [31:0] acc_mem_rdata = '0;
   logic        dst_we;
   logic [31:0] dst_addr;
   logic [31:0] dst_wdata;

   accel_seq_ctrl dut (
      .clk(clk), .rst(rst),
      .cfg_start(cfg_start), .cfg_in_words(cfg_in_words),
      .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
      .busy(busy), .done_irq(done_irq), .status(status),
      .src_en(src_en), .src_addr(src_addr), .src_rdata(src_rdata),
      .acc_start(acc_start), .acc_done(acc_done),
      .acc_out_len(acc_out_len),
      .acc_mem_en(acc_mem_en), .acc_mem_we(acc_mem_we),
      .acc_mem_addr(acc_mem_addr), .acc_mem_be(acc_mem_be),
      .acc_mem_wdata(acc_mem_wdata), .acc_mem_rdata(acc_mem_rdata),
      .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic [1:0] st;
      int         sel;
      int         gap;
   } dn_t;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] q_src[$];
   wr_t         q_acc[$];
   logic [31:0] q_ard[$];
   wr_t         q_dst[$];
   dn_t         q_done[$];

   int cyc = 0;
   int cfg_cyc = 0;
   int accst_cyc = 0;
   int accst_cnt = 0;
   int done_cnt = 0;

   logic [31:0] src_mem[64];
   logic [31:0] acc_mem[64];
   logic [31:0] cur_src_base = '0;
   logic [31:0] src_off;
   int          acc_delay = -1;
   logic [5:0]  acc_len = '0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_evt(input string nm, input logic [63:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0h expected no event", nm, act);
   endtask

   // Source memory: word offset from the current job's base.
   assign src_off = src_addr - cur_src_base;
   always @(posedge clk)
      if (src_en)
         src_rdata <= (src_off[31:8] == 0 && src_off[1:0] == 0) ?
                      src_mem[src_off[7:2]] : 32'hBAD0_BAD0;

   // Accelerator memory; the accelerator is an identity function.
   always @(posedge clk)
      if (acc_mem_en) begin
         if (acc_mem_we) acc_mem[acc_mem_addr[5:0]] <= acc_mem_wdata;
         else acc_mem_rdata <= acc_mem[acc_mem_addr[5:0]];
      end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && acc_start && acc_delay >= 0) begin
            repeat (acc_delay) @(posedge clk);
            #1 acc_done = 1'b1;
            acc_out_len = acc_len;
            @(posedge clk);
            #1 acc_done = 1'b0;
            acc_out_len = '0;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT shows an event.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (cfg_start) cfg_cyc = cyc;
         if (acc_start) begin
            accst_cyc = cyc;
            accst_cnt++;
         end
         if (src_en) begin
            if (q_src.size() == 0) fail_evt("src_extra", src_addr);
            else chk("src_addr", src_addr, q_src.pop_front());
         end
         if (acc_mem_en && acc_mem_we) begin
            if (q_acc.size() == 0) fail_evt("accwr_extra", acc_mem_addr);
            else begin
               wr_t w;
               w = q_acc.pop_front();
               chk("accwr_addr", acc_mem_addr, w.a);
               chk("accwr_data", acc_mem_wdata, w.d);
               chk("accwr_be", acc_mem_be, 4'hF);
            end
         end
         if (acc_mem_en && !acc_mem_we) begin
            if (q_ard.size() == 0) fail_evt("accrd_extra", acc_mem_addr);
            else chk("accrd_addr", acc_mem_addr, q_ard.pop_front());
         end
         if (dst_we) begin
            if (q_dst.size() == 0) fail_evt("dst_extra", dst_addr);
            else begin
               wr_t w;
               w = q_dst.pop_front();
               chk("dst_addr", dst_addr, w.a);
               chk("dst_data", dst_wdata, w.d);
            end
         end
         if (done_irq) begin
            done_cnt++;
            if (q_done.size() == 0) fail_evt("done_extra", status);
            else begin
               dn_t d;
               d = q_done.pop_front();
               chk("done_status", status, d.st);
               if (d.sel == 1) chk("done_gap_cfg", cyc - cfg_cyc, d.gap);
               if (d.sel == 2) chk("done_gap_acc", cyc - accst_cyc, d.gap);
            end
         end
      end
   end

   task automatic chk_zero(input string p);
      chk({p, "_ctl"}, {busy, done_irq, status, src_en, acc_start,
                        acc_mem_en, acc_mem_we, dst_we, acc_mem_be}, 0);
      chk({p, "_addr"}, {src_addr, dst_addr}, 0);
      chk({p, "_acc"}, {acc_mem_addr, acc_mem_wdata}, 0);
      chk({p, "_dwd"}, dst_wdata, 0);
   endtask

   task automatic flush();
      q_src.delete();
      q_acc.delete();
      q_ard.delete();
      q_dst.delete();
      q_done.delete();
   endtask

   task automatic drive_cfg(input int n, input logic [31:0] sb,
                            input logic [31:0] db);
      @(posedge clk);
      #1 cfg_start = 1'b1;
      cfg_in_words = 6'(n);
      cfg_src_base = sb;
      cfg_dst_base = db;
      @(posedge clk);
      #1 cfg_start = 1'b0;
   endtask

   task automatic run_job(input string nm, input int n,
                          input logic [31:0] sb, input logic [31:0] db,
                          input int delay, input logic [5:0] olen,
                          input logic [1:0] est, input int sel,
                          input int gap, input bit inject);
      int  m;
      int  d0;
      int  a0;
      int  inj;
      bit  ok;
      dn_t d;
      cur_src_base = sb;
      acc_delay = delay;
      acc_len = olen;
      ok = (n >= 1 && n <= 43);
      if (ok)
         for (int k = 0; k < n; k++) begin
            q_src.push_back(sb + 32'(4 * k));
            q_acc.push_back({32'(k), src_mem[k]});
         end
      if (ok && delay >= 0) begin
         m = (int'(olen) + 3) / 4;
         for (int j = 0; j < m; j++) begin
            q_ard.push_back(32'(j));
            q_dst.push_back({db + 32'(4 * j), src_mem[j]});
         end
      end
      d.st = est;
      d.sel = sel;
      d.gap = gap;
      q_done.push_back(d);
      d0 = done_cnt;
      a0 = accst_cnt;
      inj = 0;
      drive_cfg(n, sb, db);
      @(negedge clk);
      chk({nm, "_busy"}, busy, 1);
      for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
         @(negedge clk);
         cfg_start = 1'b0;
         if (inject && accst_cnt > a0 && inj < 6) begin
            inj++;
            if (inj == 5) begin
               cfg_start = 1'b1;
               cfg_in_words = 6'd3;
               cfg_src_base = 32'h0000_9000;
               cfg_dst_base = 32'h0000_A000;
            end
         end
      end
      cfg_start = 1'b0;
      if (done_cnt == d0) begin
         fail_evt({nm, "_done_timeout"}, 0);
         flush();
      end
      repeat (8) @(negedge clk);
      chk({nm, "_ndone"}, done_cnt, d0 + 1);
      chk({nm, "_nstart"}, accst_cnt, a0 + (ok ? 1 : 0));
      chk({nm, "_qleft"}, q_src.size() + q_acc.size() +
          q_ard.size() + q_dst.size() + q_done.size(), 0);
      chk({nm, "_idle"}, busy, 0);
      flush();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         src_mem[i] = '0;
         acc_mem[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      rst = 1'b0;

      // Nominal: 43 words in, 32 bytes (8 words) out.
      src_mem[0] = 32'h5555_5555;
      src_mem[1] = 32'h8000_0000;
      src_mem[42] = 32'h0000_0001;
      run_job("nominal", 43, 32'h2000_0000, 32'h3000_0100,
              20, 6'd32, 2'd0, 0, 0, 0);

      // Length errors: no strobes, done two cycles after request.
      run_job("len0", 0, 32'h100, 32'h200, -1, 6'd0, 2'd2, 1, 2, 0);
      run_job("len44", 44, 32'h100, 32'h200, -1, 6'd0, 2'd2, 1, 2, 0);

      // Minimal job with zero output length.
      src_mem[0] = 32'hCAFE_F00D;
      run_job("n1_m0", 1, 32'h800, 32'h900, 1, 6'd0, 2'd0, 0, 0, 0);

      // Timeout: no acc_done ever.
      src_mem[0] = 32'h1234_5678;
      src_mem[1] = 32'h9ABC_DEF0;
      run_job("tmo", 2, 32'h40, 32'h80, -1, 6'd0, 2'd1, 2, T + 1, 0);

      // Ceiling and wrap on both source and destination.
      src_mem[0] = 32'hA1A1_A1A1;
      src_mem[1] = 32'hB2B2_B2B2;
      src_mem[2] = 32'hC3C3_C3C3;
      run_job("wrap", 3, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
              3, 6'd5, 2'd0, 0, 0, 0);

      // Reset while loading word 10.
      for (int i = 0; i < 20; i++) src_mem[i] = 32'h1000_0000 + 32'(i);
      cur_src_base = 32'h400;
      acc_delay = 5;
      for (int k = 0; k <= 10; k++)
         q_src.push_back(32'h400 + 32'(4 * k));
      for (int k = 0; k < 10; k++)
         q_acc.push_back({32'(k), src_mem[k]});
      begin
         int d0;
         bit hit;
         d0 = done_cnt;
         hit = 0;
         drive_cfg(20, 32'h400, 32'h500);
         for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = src_en && src_addr == 32'h428;
         end
         if (!hit) fail_evt("rst_word10_timeout", 0);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 chk_zero("midrst");
         #1 rst = 1'b0;
         repeat (20) @(negedge clk);
         chk("midrst_nodone", done_cnt, d0);
         chk("midrst_qleft", q_src.size() + q_acc.size(), 0);
         chk("midrst_idle", busy, 0);
         flush();
      end
      run_job("after_rst", 12, 32'h400, 32'h700,
              5, 6'd12, 2'd0, 0, 0, 0);

      // cfg_start pulsed while waiting on the accelerator.
      for (int i = 0; i < 4; i++) src_mem[i] = 32'hD00D_0000 + 32'(i);
      run_job("wait_cfg", 4, 32'h5000, 32'h6000,
              30, 6'd16, 2'd0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
